// File: rtl/mips_trace_buffer_pkg.sv
// Shared trace-record layout for the mips trace buffer: record geometry,
// word-index encoding and the helper that picks one 32-bit word out of a record.
package mips_trace_buffer_pkg;

  localparam int TRACE_WORDS = 3;
  localparam int TRACE_REC_W = 96;

  typedef enum logic [1:0] {
    IDX_PC  = 2'd0,
    IDX_ULA = 2'd1,
    IDX_MEM = 2'd2
  } word_idx_e;

  // Record packing is {next_pc, ula_result, data_mem}, so next_pc is the top word.
  function automatic logic [31:0] trace_word(input logic [TRACE_REC_W-1:0] rec,
                                             input word_idx_e idx);
    logic [31:0] w_word;
    case (idx)
      IDX_PC:  w_word = rec[95:64];
      IDX_ULA: w_word = rec[63:32];
      IDX_MEM: w_word = rec[31:0];
      default: w_word = '0;
    endcase
    return w_word;
  endfunction

endpackage

// File: rtl/mips_trace_buffer_fifo.sv
// Generic synchronous FIFO with occupancy count, head-data output and
// synchronous clear; the caller guarantees no push when full without a pop.
module mips_trace_buffer_fifo
  import mips_trace_buffer_pkg::*;
#(
  parameter int WIDTH = TRACE_REC_W,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  // Storage needs no reset: the head word is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      r_mem[r_wrPtr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + 1'b1;
      if (pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rdPtr];
  assign count = r_count;

endmodule

// File: rtl/mips_trace_buffer.sv
// Captures {next_pc, ula_result, data_mem} records into a FIFO and streams each
// record out as three 32-bit words over valid/ready; overflow drops and counts records.
module mips_trace_buffer
  import mips_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   capture_en,
  input  logic [31:0]            next_pc,
  input  logic [31:0]            ula_result,
  input  logic [31:0]            data_mem,
  output logic [31:0]            out_data,
  output logic [1:0]             out_word_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam word_idx_e LAST_IDX = word_idx_e'(TRACE_WORDS - 1);

  word_idx_e              r_idx;
  logic                   r_overflow;
  logic [DROP_W-1:0]      r_dropCount;
  logic [TRACE_REC_W-1:0] w_head;
  logic [CW-1:0]          w_count;
  logic                   w_valid;
  logic                   w_fire;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign w_valid = (w_count != '0);
  assign w_fire  = w_valid && out_ready && !clear;
  assign w_pop   = w_fire && (r_idx == LAST_IDX);
  assign w_push  = capture_en && !clear && ((w_count != FULL_CNT) || w_pop);
  assign w_drop  = capture_en && !clear && (w_count == FULL_CNT) && !w_pop;

  mips_trace_buffer_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({next_pc, ula_result, data_mem}),
    .head  (w_head),
    .count (w_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= IDX_PC;
    end else if (clear) begin
      r_idx <= IDX_PC;
    end else if (w_fire) begin
      case (r_idx)
        IDX_PC:  r_idx <= IDX_ULA;
        IDX_ULA: r_idx <= IDX_MEM;
        default: r_idx <= IDX_PC;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (clear) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_dropCount != '1) r_dropCount <= r_dropCount + 1'b1;
    end
  end

  assign out_valid    = w_valid;
  assign out_word_idx = r_idx;
  assign out_data     = w_valid ? trace_word(w_head, r_idx) : '0;
  assign count        = w_count;
  assign overflow     = r_overflow;
  assign drop_count   = r_dropCount;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed scoreboard bench for mips_trace_buffer: a record queue models the FIFO
// and every output is compared against it with immediate assertions.
module tb_mips_trace_buffer;

  logic        clock;
  logic        reset;
  logic        clear;
  logic        capture_en;
  logic [31:0] next_pc;
  logic [31:0] ula_result;
  logic [31:0] data_mem;
  logic [31:0] out_data;
  logic [1:0]  out_word_idx;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] drop_count;

  int vectors;
  int miscompares;

  logic [95:0] sbQueue[$];
  int          mCount;
  logic [1:0]  mIdx;
  logic        mOverflow;
  logic [15:0] mDrop;

  mips_trace_buffer #(
    .DEPTH  (8),
    .DROP_W (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .capture_en   (capture_en),
    .next_pc      (next_pc),
    .ula_result   (ula_result),
    .data_mem     (data_mem),
    .out_data     (out_data),
    .out_word_idx (out_word_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelWord(input logic [95:0] rec, input logic [1:0] idx);
    if (idx == 2'd0) return rec[95:64];
    if (idx == 2'd1) return rec[63:32];
    return rec[31:0];
  endfunction

  task automatic modelReset();
    sbQueue.delete();
    mCount    = 0;
    mIdx      = 2'd0;
    mOverflow = 1'b0;
    mDrop     = 16'd0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".count"}, {28'd0, count}, mCount);
    checkOutput({tag, ".overflow"}, {31'd0, overflow}, {31'd0, mOverflow});
    checkOutput({tag, ".drop"}, {16'd0, drop_count}, {16'd0, mDrop});
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance the model, check state.
  task automatic applyStimulus(input string tag, input logic cap, input logic [31:0] pc,
                               input logic [31:0] ula, input logic [31:0] mem,
                               input logic rdy, input logic clr);
    logic fire, pop, full, acc;
    logic [31:0] expData;
    capture_en = cap;
    next_pc    = pc;
    ula_result = ula;
    data_mem   = mem;
    out_ready  = rdy;
    clear      = clr;
    #1;
    expData = (mCount != 0) ? modelWord(sbQueue[0], mIdx) : 32'd0;
    checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, (mCount != 0)});
    checkOutput({tag, ".idx"}, {30'd0, out_word_idx}, {30'd0, mIdx});
    checkOutput({tag, ".data"}, out_data, expData);
    if (clr) begin
      modelReset();
    end else begin
      fire = (mCount != 0) && rdy;
      pop  = fire && (mIdx == 2'd2);
      full = (mCount == 8);
      acc  = cap && (!full || pop);
      if (pop) void'(sbQueue.pop_front());
      if (fire) mIdx = (mIdx == 2'd2) ? 2'd0 : mIdx + 2'd1;
      if (acc) sbQueue.push_back({pc, ula, mem});
      if (cap && !acc) begin
        mOverflow = 1'b1;
        if (mDrop != 16'hFFFF) mDrop = mDrop + 16'd1;
      end
      mCount = sbQueue.size();
    end
    @(posedge clock);
    #1;
    checkState(tag);
  endtask

  task automatic drainAll(input string tag);
    for (int i = 0; i < 40 && mCount != 0; i++) begin
      applyStimulus(tag, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    checkOutput({tag, ".empty"}, {28'd0, count}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    clear       = 1'b0;
    capture_en  = 1'b0;
    next_pc     = '0;
    ula_result  = '0;
    data_mem    = '0;
    out_ready   = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset.idx", {30'd0, out_word_idx}, 32'd0);
    checkOutput("reset.data", out_data, 32'd0);
    checkState("reset");
    reset = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] single record capture and drain");
    applyStimulus("t1.cap", 1'b1, 32'h4, 32'h10, 32'hAB, 1'b1, 1'b0);
    checkOutput("t1.latency", {31'd0, out_valid}, 32'd1);
    drainAll("t1.drain");

    $display("[TB] overflow with stalled sink");
    for (int i = 0; i < 10; i++) begin
      applyStimulus("t2.cap", 1'b1, 32'h100 + i, 32'h200 + i, 32'h300 + i, 1'b0, 1'b0);
    end
    checkOutput("t2.full", {28'd0, count}, 32'd8);
    checkOutput("t2.drop2", {16'd0, drop_count}, 32'd2);

    $display("[TB] simultaneous push and pop while full");
    applyStimulus("t3.w0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("t3.w1", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("t3.w2", 1'b1, 32'hCAFE, 32'hBEEF, 32'hF00D, 1'b1, 1'b0);
    checkOutput("t3.count8", {28'd0, count}, 32'd8);
    checkOutput("t3.drop2", {16'd0, drop_count}, 32'd2);
    drainAll("t3.drain");

    $display("[TB] stalls inside a record");
    applyStimulus("t4.cap", 1'b1, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
    applyStimulus("t4.r1", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("t4.r0a", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("t4.r0b", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus("t4.r1b", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drainAll("t4.drain");

    $display("[TB] clear with queued records");
    for (int i = 0; i < 5; i++) begin
      applyStimulus("t5.cap", 1'b1, 32'h500 + i, 32'h600 + i, 32'h700 + i, 1'b0, 1'b0);
    end
    applyStimulus("t5.clear", 1'b1, 32'hDEAD, 32'hDEAD, 32'hDEAD, 1'b1, 1'b1);
    checkOutput("t5.count0", {28'd0, count}, 32'd0);
    checkOutput("t5.valid0", {31'd0, out_valid}, 32'd0);
    applyStimulus("t5.idle", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-record");
    applyStimulus("t6.cap", 1'b1, 32'h77, 32'h88, 32'h99, 1'b0, 1'b0);
    applyStimulus("t6.w0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    checkOutput("t6.idx1", {30'd0, out_word_idx}, 32'd1);
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("t6.async.valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6.async.idx", {30'd0, out_word_idx}, 32'd0);
    checkOutput("t6.async.data", out_data, 32'd0);
    checkOutput("t6.async.count", {28'd0, count}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus("t6.recap", 1'b1, 32'hA1, 32'hB2, 32'hC3, 1'b0, 1'b0);
    checkOutput("t6.idx0", {30'd0, out_word_idx}, 32'd0);
    drainAll("t6.drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
